// File: rtl/stack_sequencer_pkg.sv
// Shared encodings, FSM states and depth rules
// for the SmartStack sequencer.
package stack_ctl_pkg;

    localparam logic [2:0] F_PUSH   = 3'b000;
    localparam logic [2:0] F_D1PUSH = 3'b001;
    localparam logic [2:0] F_D2PUSH = 3'b010;
    localparam logic [2:0] F_SWAP   = 3'b011;
    localparam logic [2:0] F_DROP   = 3'b100;
    localparam logic [2:0] F_DROP2  = 3'b101;
    localparam logic [2:0] F_ROLL   = 3'b110;
    localparam logic [2:0] F_PEEK   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STORE,
        S_CAPTURE,
        S_RESP
    } state_e;

    function automatic int min_depth(input logic [2:0] f);
        int m;
        case (f)
            F_D1PUSH, F_DROP:            m = 1;
            F_D2PUSH, F_SWAP, F_DROP2:   m = 2;
            F_ROLL:                      m = 3;
            default:                     m = 0;
        endcase
        return m;
    endfunction

    function automatic int depth_delta(input logic [2:0] f);
        int d;
        case (f)
            F_PUSH:           d = 1;
            F_D2PUSH, F_DROP: d = -1;
            F_DROP2:          d = -2;
            default:          d = 0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Requester, stack and status signals of the sequencer.
// master = environment side, slave = sequencer side.
interface stack_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);

    logic                     i_req0_valid;
    logic                     i_req1_valid;
    logic                     o_req0_ready;
    logic                     o_req1_ready;
    logic [2:0]               i_req0_func;
    logic [2:0]               i_req1_func;
    logic [WIDTH-1:0]         i_req0_data;
    logic [WIDTH-1:0]         i_req1_data;
    logic                     o_stk_fetch;
    logic                     o_stk_store;
    logic [2:0]               o_stk_func;
    logic [WIDTH-1:0]         o_stk_data;
    logic [WIDTH-1:0]         i_stk_A;
    logic [WIDTH-1:0]         i_stk_B;
    logic                     o_rsp_valid;
    logic                     o_rsp_port;
    logic                     o_rsp_err;
    logic [WIDTH-1:0]         o_rsp_A;
    logic [WIDTH-1:0]         o_rsp_B;
    logic [$clog2(DEPTH)-1:0] o_depth;
    logic                     o_empty;
    logic                     o_full;

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_func, i_req1_func,
        output i_req0_data, i_req1_data,
        output i_stk_A, i_stk_B,
        input  o_req0_ready, o_req1_ready,
        input  o_stk_fetch, o_stk_store,
        input  o_stk_func, o_stk_data,
        input  o_rsp_valid, o_rsp_port, o_rsp_err,
        input  o_rsp_A, o_rsp_B,
        input  o_depth, o_empty, o_full
    );

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_func, i_req1_func,
        input  i_req0_data, i_req1_data,
        input  i_stk_A, i_stk_B,
        output o_req0_ready, o_req1_ready,
        output o_stk_fetch, o_stk_store,
        output o_stk_func, o_stk_data,
        output o_rsp_valid, o_rsp_port, o_rsp_err,
        output o_rsp_A, o_rsp_B,
        output o_depth, o_empty, o_full
    );

endinterface

// File: rtl/stack_sequencer_rr_arbiter.sv
// Two-port round-robin grant; the pointer flips
// to the other port on every advance.
module stack_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = valid_i;
        if (valid_i[0] && valid_i[1]) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Arbitrates two requesters and drives the SmartStack
// fetch/store pair, tracking depth to reject bad ops.
module stack_sequencer
    import stack_ctl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    stack_sequencer_if.slave  bus
);

    localparam int DW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [2:0]       func_q, func_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             port_q, port_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rsp_a_q, rsp_a_d;
    logic [WIDTH-1:0] rsp_b_q, rsp_b_d;
    logic [DW-1:0]    depth_q, depth_d;

    logic [1:0]       gnt;
    logic             idle_ok;
    logic             accept;
    logic             sel;
    logic [2:0]       sel_func;
    logic [WIDTH-1:0] sel_data;
    logic             legal;

    assign idle_ok  = (state_q == S_IDLE) && !i_rst;
    assign accept   = idle_ok && (gnt != 2'b00);
    assign sel      = gnt[1];
    assign sel_func = sel ? bus.i_req1_func : bus.i_req0_func;
    assign sel_data = sel ? bus.i_req1_data : bus.i_req0_data;

    // PUSH needs one spare slot below the pointer wrap
    assign legal = (int'(depth_q) >= min_depth(sel_func))
                && ((sel_func != F_PUSH)
                    || (int'(depth_q) <= DEPTH - 2));

    stack_rr_arbiter u_arb (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .valid_i   ({bus.i_req1_valid, bus.i_req0_valid}),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        data_d  = data_q;
        port_d  = port_q;
        err_d   = err_q;
        rsp_a_d = rsp_a_q;
        rsp_b_d = rsp_b_q;
        depth_d = depth_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    func_d  = sel_func;
                    data_d  = sel_data;
                    port_d  = sel;
                    err_d   = !legal;
                    rsp_a_d = '0;
                    rsp_b_d = '0;
                    state_d = legal ? S_FETCH : S_RESP;
                end
            end
            S_FETCH: state_d = S_STORE;
            S_STORE: begin
                depth_d = DW'(int'(depth_q)
                              + depth_delta(func_q));
                state_d = (func_q == F_PEEK) ? S_CAPTURE
                                             : S_RESP;
            end
            S_CAPTURE: begin
                rsp_a_d = bus.i_stk_A;
                rsp_b_d = bus.i_stk_B;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            func_q  <= '0;
            data_q  <= '0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            data_q  <= data_d;
            port_q  <= port_d;
            err_q   <= err_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
            depth_q <= depth_d;
        end
    end

    logic strobe;
    assign strobe = (state_q == S_FETCH) || (state_q == S_STORE);

    assign bus.o_req0_ready = idle_ok && gnt[0];
    assign bus.o_req1_ready = idle_ok && gnt[1];
    assign bus.o_stk_fetch  = (state_q == S_FETCH);
    assign bus.o_stk_store  = (state_q == S_STORE);
    assign bus.o_stk_func   = strobe ? func_q : 3'b000;
    assign bus.o_stk_data   = strobe ? data_q : '0;
    assign bus.o_rsp_valid  = (state_q == S_RESP);
    assign bus.o_rsp_port   = port_q;
    assign bus.o_rsp_err    = err_q;
    assign bus.o_rsp_A      = rsp_a_q;
    assign bus.o_rsp_B      = rsp_b_q;
    assign bus.o_depth      = depth_q;
    assign bus.o_empty      = (depth_q == '0);
    assign bus.o_full       = (depth_q == DW'(DEPTH - 1));

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a SmartStack
// stand-in and a transaction-level reference model.
module tb_stack_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam logic [2:0] PUSH   = 3'b000;
    localparam logic [2:0] D1PUSH = 3'b001;
    localparam logic [2:0] D2PUSH = 3'b010;
    localparam logic [2:0] SWAP   = 3'b011;
    localparam logic [2:0] DROP   = 3'b100;
    localparam logic [2:0] DROP2  = 3'b101;
    localparam logic [2:0] ROLL   = 3'b110;
    localparam logic [2:0] PEEK   = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // SmartStack stand-in: acts on store, A/B are top two
    logic [15:0] mem [DEPTH];
    int          sp = 0;
    logic [15:0] tmp, tmp2;

    function automatic logic [15:0] top_at(input int k);
        if (sp > k) return mem[sp-1-k];
        return 16'hDEAD;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sp = 0;
        end else if (bus.o_stk_store) begin
            case (bus.o_stk_func)
                PUSH: begin
                    mem[sp] = bus.o_stk_data;
                    sp = sp + 1;
                end
                D1PUSH: mem[sp-1] = bus.o_stk_data;
                D2PUSH: begin
                    mem[sp-2] = bus.o_stk_data;
                    sp = sp - 1;
                end
                SWAP: begin
                    tmp = mem[sp-1];
                    mem[sp-1] = mem[sp-2];
                    mem[sp-2] = tmp;
                end
                DROP:  sp = sp - 1;
                DROP2: sp = sp - 2;
                ROLL: begin
                    tmp  = mem[sp-1];
                    tmp2 = mem[sp-3];
                    mem[sp-3] = mem[sp-2];
                    mem[sp-2] = tmp;
                    mem[sp-1] = tmp2;
                end
                default: ;
            endcase
            if (sp < 0) sp = 0;
            if (sp > DEPTH) sp = DEPTH;
        end
        bus.i_stk_A <= top_at(0);
        bus.i_stk_B <= top_at(1);
    end

    function automatic int need(input logic [2:0] f);
        case (f)
            D1PUSH, DROP:        return 1;
            D2PUSH, SWAP, DROP2: return 2;
            ROLL:                return 3;
            default:             return 0;
        endcase
    endfunction

    function automatic int change(input logic [2:0] f);
        case (f)
            PUSH:         return 1;
            D2PUSH, DROP: return -1;
            DROP2:        return -2;
            default:      return 0;
        endcase
    endfunction

    // Reference model: ph = cycles since acceptance (0 = idle)
    int          ph = 0;
    int          m_depth = 0;
    bit          m_ptr = 0;
    bit          m_err = 0;
    bit          m_port = 0;
    logic [2:0]  m_f = 3'b000;
    logic [15:0] m_d = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    bit          chk_en = 0;
    bit          g0, g1, v0, v1;
    bit          e_fetch, e_store, e_rsp;

    always @(negedge clk) begin
        v0 = bus.i_req0_valid;
        v1 = bus.i_req1_valid;
        g0 = 0;
        g1 = 0;
        if (ph == 0 && !rst) begin
            if (v0 && v1) begin
                g0 = !m_ptr;
                g1 = m_ptr;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        e_fetch = !m_err && ph == 1;
        e_store = !m_err && ph == 2;
        e_rsp   = m_err ? (ph == 1)
                        : (ph == ((m_f == PEEK) ? 4 : 3));
        if (chk_en) begin
            chk("ready0", 32'(bus.o_req0_ready), 32'(g0));
            chk("ready1", 32'(bus.o_req1_ready), 32'(g1));
            chk("fetch", 32'(bus.o_stk_fetch), 32'(e_fetch));
            chk("store", 32'(bus.o_stk_store), 32'(e_store));
            chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(e_rsp));
            if (e_rsp) begin
                chk("rsp_port", 32'(bus.o_rsp_port), 32'(m_port));
                chk("rsp_err", 32'(bus.o_rsp_err), 32'(m_err));
                chk("rsp_A", 32'(bus.o_rsp_A), 32'(m_a));
                chk("rsp_B", 32'(bus.o_rsp_B), 32'(m_b));
            end
            if (e_fetch || e_store) begin
                chk("stk_func", 32'(bus.o_stk_func), 32'(m_f));
                chk("stk_data", 32'(bus.o_stk_data), 32'(m_d));
            end
            if (ph == 0) begin
                chk("idle_func", 32'(bus.o_stk_func), 0);
                chk("idle_data", 32'(bus.o_stk_data), 0);
            end
            chk("depth", 32'(bus.o_depth), 32'(m_depth));
            chk("empty", 32'(bus.o_empty), 32'(m_depth == 0));
            chk("full", 32'(bus.o_full),
                32'(m_depth == DEPTH - 1));
        end
        if (rst) begin
            ph = 0;
            m_depth = 0;
            m_ptr = 0;
            m_err = 0;
            chk_en = 1;
        end else if (ph == 0) begin
            if (g0 || g1) begin
                m_port = g1;
                m_f = g1 ? bus.i_req1_func : bus.i_req0_func;
                m_d = g1 ? bus.i_req1_data : bus.i_req0_data;
                m_err = !(m_depth >= need(m_f)
                          && !(m_f == PUSH && m_depth > DEPTH - 2));
                m_ptr = !g1;
                m_a = '0;
                m_b = '0;
                if (!m_err && m_f == PEEK) begin
                    m_a = top_at(0);
                    m_b = top_at(1);
                end
                ph = 1;
            end
        end else begin
            if (e_store) m_depth = m_depth + change(m_f);
            ph = e_rsp ? 0 : ph + 1;
        end
    end

    int          r_lat;
    bit          r_got;
    logic        r_err;
    logic        r_port;
    logic [15:0] r_a, r_b;

    task automatic req(input int p, input logic [2:0] f,
                       input logic [15:0] d);
        int n;
        bit ok;
        if (p == 0) begin
            bus.i_req0_valid = 1'b1;
            bus.i_req0_func  = f;
            bus.i_req0_data  = d;
        end else begin
            bus.i_req1_valid = 1'b1;
            bus.i_req1_func  = f;
            bus.i_req1_data  = d;
        end
        ok = 0;
        n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            ok = (p == 0) ? bus.o_req0_ready : bus.o_req1_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL handshake: got timeout want ready p%0d", p);
        end
        @(posedge clk);
        #1;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        r_lat = 0;
        r_got = 0;
        r_err = 1'bx;
        r_port = 1'bx;
        r_a = 'x;
        r_b = 'x;
        while (!r_got && r_lat < 10) begin
            @(negedge clk);
            r_lat++;
            if (bus.o_rsp_valid) begin
                r_got  = 1;
                r_err  = bus.o_rsp_err;
                r_port = bus.o_rsp_port;
                r_a    = bus.o_rsp_A;
                r_b    = bus.o_rsp_B;
            end
        end
        if (!r_got) begin
            total++;
            bad++;
            $display("FAIL response: got timeout want rsp_valid");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int gseq [4];
    int rprt [4];
    int ng, nr, n, pulses;
    bit ok0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_req0_func  = 3'b000;
        bus.i_req1_func  = 3'b000;
        bus.i_req0_data  = '0;
        bus.i_req1_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_depth", 32'(bus.o_depth), 0);
        chk("rst_empty", 32'(bus.o_empty), 1);
        chk("rst_full", 32'(bus.o_full), 0);
        chk("rst_rsp", 32'(bus.o_rsp_valid), 0);
        chk("rst_rspA", 32'(bus.o_rsp_A), 0);
        chk("rst_port", 32'(bus.o_rsp_port), 0);
        @(posedge clk);
        #1;

        req(0, DROP, 16'h0);
        chk("under_err", 32'(r_err), 1);
        chk("under_lat", r_lat, 1);
        chk("under_depth", 32'(bus.o_depth), 0);

        req(0, PUSH, 16'h1111);
        chk("push_lat", r_lat, 3);
        chk("push_err", 32'(r_err), 0);
        req(0, PUSH, 16'h2222);
        req(0, PEEK, 16'h0);
        chk("peek_lat", r_lat, 4);
        chk("peek_A", 32'(r_a), 32'h2222);
        chk("peek_B", 32'(r_b), 32'h1111);
        chk("peek_err", 32'(r_err), 0);
        chk("peek_depth", 32'(bus.o_depth), 2);

        for (int i = 0; i < 5; i++) req(0, PUSH, 16'h0100 + 16'(i));
        chk("full_depth", 32'(bus.o_depth), 7);
        chk("full_flag", 32'(bus.o_full), 1);
        req(0, PUSH, 16'h9999);
        chk("over_err", 32'(r_err), 1);
        chk("over_lat", r_lat, 1);
        req(0, DROP2, 16'h0);
        chk("drop2_err", 32'(r_err), 0);
        chk("drop2_depth", 32'(bus.o_depth), 5);

        pulse_reset();
        req(0, PEEK, 16'h0);
        chk("empty_peek_A", 32'(r_a), 32'hDEAD);
        chk("empty_peek_B", 32'(r_b), 32'hDEAD);
        req(0, PUSH, 16'h000A);
        req(0, PUSH, 16'h000B);
        req(0, PUSH, 16'h000C);
        req(0, ROLL, 16'h0);
        req(0, PEEK, 16'h0);
        chk("roll_A", 32'(r_a), 32'h000A);
        chk("roll_B", 32'(r_b), 32'h000C);
        req(0, SWAP, 16'h0);
        req(0, PEEK, 16'h0);
        chk("swap_A", 32'(r_a), 32'h000C);
        chk("swap_B", 32'(r_b), 32'h000A);
        req(1, D1PUSH, 16'h00EE);
        req(1, PEEK, 16'h0);
        chk("d1_A", 32'(r_a), 32'h00EE);
        chk("d1_port", 32'(r_port), 1);

        pulse_reset();
        bus.i_req0_valid = 1'b1;
        bus.i_req0_func  = PUSH;
        bus.i_req0_data  = 16'h0A0A;
        bus.i_req1_valid = 1'b1;
        bus.i_req1_func  = PUSH;
        bus.i_req1_data  = 16'h0B0B;
        ng = 0;
        nr = 0;
        n = 0;
        while (ng < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.o_rsp_valid && nr < 4) begin
                rprt[nr] = int'(bus.o_rsp_port);
                nr++;
            end
            if (bus.o_req0_ready) begin
                gseq[ng] = 0;
                ng++;
            end else if (bus.o_req1_ready) begin
                gseq[ng] = 1;
                ng++;
            end
        end
        @(posedge clk);
        #1;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        while (nr < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (bus.o_rsp_valid) begin
                rprt[nr] = int'(bus.o_rsp_port);
                nr++;
            end
        end
        chk("arb_grants", 32'(ng), 4);
        chk("arb_rsps", 32'(nr), 4);
        for (int i = 0; i < 4; i++) begin
            chk("arb_gnt", 32'(gseq[i]), 32'(i % 2));
            chk("arb_rsp_port", 32'(rprt[i]), 32'(i % 2));
        end
        @(posedge clk);
        #1;
        chk("arb_depth", 32'(bus.o_depth), 4);
        req(0, PEEK, 16'h0);
        chk("arb_A", 32'(r_a), 32'h0B0B);
        chk("arb_B", 32'(r_b), 32'h0A0A);

        pulse_reset();
        bus.i_req0_valid = 1'b1;
        bus.i_req0_func  = PUSH;
        bus.i_req0_data  = 16'h7777;
        ok0 = 0;
        n = 0;
        while (!ok0 && n < 20) begin
            @(negedge clk);
            n++;
            ok0 = bus.o_req0_ready;
        end
        chk("mid_hs", 32'(ok0), 1);
        @(posedge clk);
        #1;
        bus.i_req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_fetch", 32'(bus.o_stk_fetch), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_store", 32'(bus.o_stk_store), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_depth", 32'(bus.o_depth), 0);
        chk("mid_empty", 32'(bus.o_empty), 1);
        chk("mid_nostore", 32'(bus.o_stk_store), 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("mid_norsp", 32'(pulses), 0);
        @(posedge clk);
        #1;
        req(0, PUSH, 16'h5555);
        req(0, PEEK, 16'h0);
        chk("post_A", 32'(r_a), 32'h5555);
        chk("post_B", 32'(r_b), 32'hDEAD);
        chk("post_depth", 32'(bus.o_depth), 1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
